// File: rtl/uart_inst_rx_if.sv
// Instruction byte handshake between the UART program loader and its consumer.
interface uart_inst_rx_if;
   logic [7:0] inst_wd;
   logic       inst_vld;
   logic       inst_rdy;

   modport master (output inst_wd, output inst_vld, input inst_rdy);
   modport slave  (input inst_wd, input inst_vld, output inst_rdy);
endinterface

// File: rtl/uart_inst_rx.sv
// 8N1 UART receiver that loads a length-prefixed program and hands each body
// byte to a consumer over a valid/ready handshake.
module uart_inst_rx #(
   parameter int unsigned CLKS_PER_BIT = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             RsRx,
   uart_inst_rx_if.master   inst,
   output logic             prog_busy,
   output logic             prog_done,
   output logic             frm_err,
   output logic             ovr_err
);

   localparam int unsigned CW      = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned HALF_M1 = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0;
   localparam int unsigned FULL_M1 = (CLKS_PER_BIT > 0) ? CLKS_PER_BIT - 1 : 0;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} bit_st_t;
   typedef enum logic {HDR, BODY} byte_st_t;

   logic          rx_m, rx_s;
   bit_st_t       bit_st, bit_nxt;
   logic [CW-1:0] clk_cnt, cnt_nxt;
   logic [2:0]    bit_idx, idx_nxt;
   logic [7:0]    shreg, sh_nxt;
   logic          byte_done, frm_nxt;

   byte_st_t      byte_st, bst_nxt;
   logic [7:0]    rem, rem_nxt;
   logic [7:0]    wd_q, wd_nxt;
   logic          vld_q, vld_nxt;
   logic          busy_nxt, done_nxt, ovr_nxt, acc;

   assign inst.inst_wd  = wd_q;
   assign inst.inst_vld = vld_q;
   assign acc           = vld_q & inst.inst_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m      <= 1'b1;
         rx_s      <= 1'b1;
         bit_st    <= IDLE;
         clk_cnt   <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         frm_err   <= 1'b0;
         byte_st   <= HDR;
         rem       <= '0;
         wd_q      <= '0;
         vld_q     <= 1'b0;
         prog_busy <= 1'b0;
         prog_done <= 1'b0;
         ovr_err   <= 1'b0;
      end else begin
         rx_m      <= RsRx;
         rx_s      <= rx_m;
         bit_st    <= bit_nxt;
         clk_cnt   <= cnt_nxt;
         bit_idx   <= idx_nxt;
         shreg     <= sh_nxt;
         frm_err   <= frm_nxt;
         byte_st   <= bst_nxt;
         rem       <= rem_nxt;
         wd_q      <= wd_nxt;
         vld_q     <= vld_nxt;
         prog_busy <= busy_nxt;
         prog_done <= done_nxt;
         ovr_err   <= ovr_nxt;
      end
   end

   always_comb begin
      bit_nxt   = bit_st;
      cnt_nxt   = clk_cnt + CW'(1);
      idx_nxt   = bit_idx;
      sh_nxt    = shreg;
      byte_done = 1'b0;
      frm_nxt   = 1'b0;
      unique case (bit_st)
         IDLE: begin
            cnt_nxt = '0;
            if (!rx_s) begin
               bit_nxt = START;
               idx_nxt = '0;
            end
         end
         START: begin
            if (clk_cnt == CW'(HALF_M1)) begin
               cnt_nxt = '0;
               bit_nxt = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (clk_cnt == CW'(FULL_M1)) begin
               cnt_nxt = '0;
               sh_nxt  = {rx_s, shreg[7:1]};
               idx_nxt = bit_idx + 3'd1;
               if (bit_idx == 3'd7) bit_nxt = STOP;
            end
         end
         STOP: begin
            if (clk_cnt == CW'(FULL_M1)) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  byte_done = 1'b1;
                  bit_nxt   = IDLE;
               end else begin
                  frm_nxt = 1'b1;
                  bit_nxt = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            cnt_nxt = '0;
            if (rx_s) bit_nxt = IDLE;
         end
         default: bit_nxt = IDLE;
      endcase
   end

   // Acceptance is resolved first so a byte landing on the final acceptance
   // edge is treated as the next length header, and a byte landing on any
   // other acceptance edge refills the output without an overrun.
   always_comb begin
      bst_nxt  = byte_st;
      rem_nxt  = rem;
      wd_nxt   = wd_q;
      vld_nxt  = vld_q;
      busy_nxt = prog_busy;
      done_nxt = 1'b0;
      ovr_nxt  = 1'b0;
      if (acc) begin
         vld_nxt = 1'b0;
         if (rem != 8'd0) rem_nxt = rem - 8'd1;
         if (rem == 8'd1) begin
            done_nxt = 1'b1;
            busy_nxt = 1'b0;
            bst_nxt  = HDR;
         end
      end
      if (byte_done) begin
         if (bst_nxt == HDR) begin
            if (shreg != 8'd0) begin
               rem_nxt  = shreg;
               busy_nxt = 1'b1;
               bst_nxt  = BODY;
            end
         end else if (!vld_nxt) begin
            wd_nxt  = shreg;
            vld_nxt = 1'b1;
         end else begin
            ovr_nxt = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_inst_rx.sv
// Scoreboard bench for uart_inst_rx: directed frames push expected bytes, a
// monitor pops and checks each accepted byte and its prog_done pulse.
module tb_uart_inst_rx;
   localparam int unsigned CPB = 16;

   typedef struct {
      logic [7:0] d;
      logic       last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic RsRx = 1'b1;
   logic prog_busy, prog_done, frm_err, ovr_err;

   uart_inst_rx_if bus ();

   uart_inst_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .RsRx      (RsRx),
      .inst      (bus),
      .prog_busy (prog_busy),
      .prog_done (prog_done),
      .frm_err   (frm_err),
      .ovr_err   (ovr_err)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   frm_cnt = 0;
   int   ovr_cnt = 0;
   int   done_cnt = 0;
   logic pend_done = 1'b0;
   exp_t exp_q[$];

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (pend_done || prog_done)
         chk(prog_done == pend_done, "prog_done_timing", 32'(prog_done), 32'(pend_done));
      pend_done = 1'b0;
      if (prog_done) done_cnt++;
      if (frm_err) frm_cnt++;
      if (ovr_err) ovr_cnt++;
      if (!rst && bus.inst_vld && bus.inst_rdy) begin
         if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_byte", 32'(bus.inst_wd), 32'h0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk(bus.inst_wd == e.d, "inst_wd", 32'(bus.inst_wd), 32'(e.d));
            pend_done = e.last;
         end
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // rst_bit selects the data bit during which a one-cycle reset is applied (-1 = none).
   task automatic send(input logic [7:0] d, input logic stop, input int rst_bit);
      RsRx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         RsRx = d[i];
         if (i == rst_bit) begin
            tick(CPB / 2);
            rst = 1'b1;
            tick(1);
            chk({bus.inst_wd, bus.inst_vld, prog_busy, prog_done, frm_err, ovr_err} == '0,
                "midframe_reset_outputs",
                32'({bus.inst_wd, bus.inst_vld, prog_busy, prog_done, frm_err, ovr_err}), 32'h0);
            rst = 1'b0;
            tick(CPB - CPB / 2 - 1);
         end else begin
            tick(CPB);
         end
      end
      RsRx = stop;
      tick(CPB);
      RsRx = 1'b1;
      tick(2 * CPB);
   endtask

   task automatic push(input logic [7:0] d, input logic last);
      exp_t e;
      e.d = d;
      e.last = last;
      exp_q.push_back(e);
   endtask

   initial begin
      int f0, o0, waited;
      bus.inst_rdy = 1'b1;
      tick(3);
      chk({bus.inst_wd, bus.inst_vld, prog_busy, prog_done, frm_err, ovr_err} == '0, "reset_outputs",
          32'({bus.inst_wd, bus.inst_vld, prog_busy, prog_done, frm_err, ovr_err}), 32'h0);
      rst = 1'b0;
      tick(4);

      // basic three-byte program
      push(8'h05, 1'b0); push(8'h1A, 1'b0); push(8'hC0, 1'b1);
      send(8'h03, 1'b1, -1);
      chk(prog_busy == 1'b1, "busy_after_len", 32'(prog_busy), 32'h1);
      send(8'h05, 1'b1, -1);
      send(8'h1A, 1'b1, -1);
      chk(prog_busy == 1'b1, "busy_before_last", 32'(prog_busy), 32'h1);
      send(8'hC0, 1'b1, -1);
      chk(prog_busy == 1'b0, "busy_after_prog1", 32'(prog_busy), 32'h0);

      // zero-length header is ignored
      send(8'h00, 1'b1, -1);
      chk(prog_busy == 1'b0, "busy_zero_len", 32'(prog_busy), 32'h0);
      push(8'h11, 1'b0); push(8'h22, 1'b1);
      send(8'h02, 1'b1, -1);
      send(8'h11, 1'b1, -1);
      send(8'h22, 1'b1, -1);

      // framing error in body leaves count untouched
      f0 = frm_cnt;
      send(8'h02, 1'b1, -1);
      send(8'h44, 1'b0, -1);
      chk(frm_cnt - f0 == 1, "frm_err_pulses", 32'(frm_cnt - f0), 32'h1);
      chk(prog_busy == 1'b1, "busy_after_frm", 32'(prog_busy), 32'h1);
      push(8'h44, 1'b0); push(8'h55, 1'b1);
      send(8'h44, 1'b1, -1);
      send(8'h55, 1'b1, -1);

      // overrun while consumer stalls
      o0 = ovr_cnt;
      bus.inst_rdy = 1'b0;
      push(8'hAA, 1'b0);
      send(8'h03, 1'b1, -1);
      send(8'hAA, 1'b1, -1);
      send(8'hBB, 1'b1, -1);
      chk(bus.inst_vld == 1'b1, "held_vld", 32'(bus.inst_vld), 32'h1);
      chk(bus.inst_wd == 8'hAA, "held_wd", 32'(bus.inst_wd), 32'hAA);
      chk(ovr_cnt - o0 == 1, "ovr_err_pulses", 32'(ovr_cnt - o0), 32'h1);
      bus.inst_rdy = 1'b1;
      tick(4);
      chk(bus.inst_wd == 8'hAA, "wd_hold_after_acc", 32'(bus.inst_wd), 32'hAA);
      push(8'hCC, 1'b0);
      send(8'hCC, 1'b1, -1);
      chk(prog_busy == 1'b1, "busy_count1", 32'(prog_busy), 32'h1);
      push(8'hDD, 1'b1);
      send(8'hDD, 1'b1, -1);
      chk(prog_busy == 1'b0, "busy_after_ovr_prog", 32'(prog_busy), 32'h0);

      // short low glitch while idle
      f0 = frm_cnt;
      RsRx = 1'b0;
      tick(5);
      RsRx = 1'b1;
      tick(12 * CPB);
      chk(prog_busy == 1'b0, "glitch_no_byte", 32'(prog_busy), 32'h0);
      chk(frm_cnt == f0, "glitch_no_err", 32'(frm_cnt), 32'(f0));
      push(8'h66, 1'b1);
      send(8'h01, 1'b1, -1);
      send(8'h66, 1'b1, -1);

      // reset during 4th data bit of a body byte
      push(8'h99, 1'b0);
      send(8'h02, 1'b1, -1);
      send(8'h99, 1'b1, -1);
      send(8'hF8, 1'b1, 3);
      chk(prog_busy == 1'b0, "busy_after_rst", 32'(prog_busy), 32'h0);
      push(8'h77, 1'b1);
      send(8'h01, 1'b1, -1);
      chk(prog_busy == 1'b1, "rst_next_is_len", 32'(prog_busy), 32'h1);
      send(8'h77, 1'b1, -1);

      waited = 0;
      while (exp_q.size() != 0 && waited < 2000) begin
         tick(1);
         waited++;
      end
      tick(4);
      chk(exp_q.size() == 0, "scoreboard_drained", 32'(exp_q.size()), 32'h0);
      chk(done_cnt == 6, "prog_done_total", 32'(done_cnt), 32'd6);
      chk(frm_cnt == 1, "frm_err_total", 32'(frm_cnt), 32'd1);
      chk(ovr_cnt == 1, "ovr_err_total", 32'(ovr_cnt), 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_inst_rx.md
UART_INST_RX -- requirements
Module: uart_inst_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 100, clk cycles per serial bit (100 MHz clk, 1 Mbaud).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port RsRx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port inst_rdy  input  1  consumer accepts inst_wd this cycle when inst_vld=1.
REQ-006 SHALL have port inst_wd  output  8  instruction byte presented to the consumer.
REQ-007 SHALL have port inst_vld  output  1  inst_wd valid; held until accepted.
REQ-008 SHALL have port prog_busy  output  1  program load in progress (length byte received, body incomplete).
REQ-009 SHALL have port prog_done  output  1  one-cycle pulse when last body byte is accepted.
REQ-010 SHALL have port frm_err  output  1  one-cycle pulse on a stop-bit error.
REQ-011 SHALL have port ovr_err  output  1  one-cycle pulse when a received body byte is dropped because inst_vld is still pending.

Function
REQ-012 SHALL pass RsRx through a two-flop synchronizer; all receive logic uses the synchronized value (rx_s).
REQ-013 Bit FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE->START on rx_s=0; bit counter cleared.
REQ-015 START: after CLKS_PER_BIT/2 cycles, sample rx_s; 0 -> DATA, 1 -> IDLE (false start, no output).
REQ-016 DATA: sample every CLKS_PER_BIT cycles; 8 samples shifted in LSB first; after 8th -> STOP.
REQ-017 STOP: sample after CLKS_PER_BIT cycles; 1 -> byte complete, IDLE; 0 -> frm_err pulse, byte discarded, WAIT_HIGH.
REQ-018 WAIT_HIGH -> IDLE on first cycle rx_s=1.
REQ-019 Byte FSM SHALL have states HDR and BODY; reset state HDR.
REQ-020 HDR: a completed byte N loads remaining count; N=0 -> stays HDR, no outputs; N>0 -> BODY, prog_busy=1.
REQ-021 BODY: completed byte with inst_vld=0 -> inst_wd=byte, inst_vld=1 on the cycle after stop-bit sample.
REQ-022 BODY: completed byte with inst_vld=1 and no acceptance that cycle -> ovr_err pulse, byte dropped, count unchanged.
REQ-023 Acceptance (inst_vld & inst_rdy) SHALL clear inst_vld next cycle and decrement count; a new byte completing in the same cycle SHALL be loaded (inst_vld stays 1), no ovr_err.
REQ-024 Acceptance bringing count to 0 SHALL pulse prog_done, clear prog_busy, return to HDR, same edge.
REQ-025 frm_err in BODY SHALL not change count or state.
REQ-026 inst_wd SHALL hold its value while inst_vld=1 and after acceptance until next load.
REQ-027 Count is 8-bit; max program 255 bytes; no wrap (decrement only when nonzero).

Reset
REQ-028 While rst=1 at a rising edge: bit FSM IDLE, byte FSM HDR, count 0, synchronizer flops 1.
REQ-029 Reset outputs: inst_wd=8'h00, inst_vld=0, prog_busy=0, prog_done=0, frm_err=0, ovr_err=0.
REQ-030 rst mid-frame or mid-program SHALL abandon the frame/program; the next start bit after rst release begins a new HDR byte.

Verification
REQ-031 Send 0x03,0x05,0x1A,0xC0, inst_rdy=1 -> inst_vld pulses carrying 0x05,0x1A,0xC0 in order; prog_done on third acceptance; prog_busy 1 from length byte until then.
REQ-032 Send 0x00 then 0x02,0x11,0x22 -> no output for 0x00; then 0x11,0x22 emitted, prog_done once.
REQ-033 Send 0x02,0x44 with stop bit forced 0, then 0x44,0x55 -> one frm_err pulse; emitted 0x44,0x55; prog_done once.
REQ-034 inst_rdy=0, send 0x03,0xAA,0xBB -> inst_wd=0xAA held, ovr_err pulse for 0xBB; raise inst_rdy, send 0xCC -> 0xCC emitted, prog_busy still 1 (count 1).
REQ-035 30-cycle low glitch on RsRx in IDLE -> no byte, no error; next valid frame decoded normally.
REQ-036 Assert rst for 1 cycle during 4th data bit of a body byte -> all outputs at reset values; next byte treated as length.
